// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register map, debounce counter sizing and
// prescaler width helper.
package gpio_pkg;

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_PENDING = 3'd5;
    localparam logic [2:0] ADDR_OUT_SET = 3'd6;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd7;

    localparam int unsigned DB_CNT_W   = 2;
    localparam int unsigned DB_CNT_MAX = 3;

    function automatic int unsigned prescale_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/gpio_input_filter.sv
// Two-flop pad synchroniser followed by an optional per-pin debounce stage
// (enabled by defining GPIO_DEBOUNCE_EN).
module gpio_input_filter
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEBOUNCE_DIV = 1200
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= D;
            sync_q2 <= sync_q1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned PW = prescale_width(DEBOUNCE_DIV);

    logic [PW-1:0]                    presc_q;
    logic                             tick;
    logic [WIDTH-1:0][DB_CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0][DB_CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]                 filt_q;
    logic [WIDTH-1:0]                 filt_d;

    assign tick = (presc_q == PW'(DEBOUNCE_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
        end
    end

    // A pin must disagree on DB_CNT_MAX consecutive ticks before the filter follows it.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (tick) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync_q2[i] != filt_q[i]) begin
                    if (cnt_q[i] == DB_CNT_W'(DB_CNT_MAX - 1)) begin
                        filt_d[i] = ~filt_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    assign Q = filt_q;
`else
    localparam int unsigned UNUSED_DEBOUNCE_DIV = DEBOUNCE_DIV;

    assign Q = sync_q2;
`endif

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction, atomic set/clear, synchronised inputs, edge
// interrupts. Input debounce is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned BITS         = 16,
    parameter int unsigned ADDRESS_BITS = 8,
    parameter int unsigned PIN_COUNT    = 8,
    parameter int unsigned DEBOUNCE_DIV = 1200
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    input  logic [PIN_COUNT-1:0]    PINS_IN,
    output logic [PIN_COUNT-1:0]    PINS_OUT,
    output logic [PIN_COUNT-1:0]    PINS_OE,
    output logic                    IRQ
);

    logic [2:0]           addr;
    logic [PIN_COUNT-1:0] wdata;
    logic                 unused_bits;

    logic [PIN_COUNT-1:0] out_q, out_d;
    logic [PIN_COUNT-1:0] dir_q, dir_d;
    logic [PIN_COUNT-1:0] rise_en_q, rise_en_d;
    logic [PIN_COUNT-1:0] fall_en_q, fall_en_d;
    logic [PIN_COUNT-1:0] pending_q, pending_d;
    logic [PIN_COUNT-1:0] prev_q;
    logic                 irq_q;

    logic [PIN_COUNT-1:0] in_filt;
    logic [PIN_COUNT-1:0] rise;
    logic [PIN_COUNT-1:0] fall;
    logic [PIN_COUNT-1:0] edge_set;
    logic [PIN_COUNT-1:0] pend_clr;
    logic [PIN_COUNT-1:0] rsel;

    assign addr  = ADDRESS[2:0];
    assign wdata = DATA_IN[PIN_COUNT-1:0];
    // Upper address/data bits are deliberately ignored.
    assign unused_bits = ^{ADDRESS, DATA_IN};

    gpio_input_filter #(
        .WIDTH        (PIN_COUNT),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_filter (
        .CLK (CLK),
        .RST (RST),
        .D   (PINS_IN),
        .Q   (in_filt)
    );

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        if (WR) begin
            unique case (addr)
                ADDR_OUT:     out_d     = wdata;
                ADDR_DIR:     dir_d     = wdata;
                ADDR_RISE_EN: rise_en_d = wdata;
                ADDR_FALL_EN: fall_en_d = wdata;
                ADDR_PENDING: pend_clr  = wdata;
                ADDR_OUT_SET: out_d     = out_q | wdata;
                ADDR_OUT_CLR: out_d     = out_q & ~wdata;
                default:      ;
            endcase
        end
    end

    // New edges are OR-ed in after the clear so a coincident edge is never lost.
    always_comb begin
        rise      = in_filt & ~prev_q;
        fall      = ~in_filt & prev_q;
        edge_set  = (rise & rise_en_q) | (fall & fall_en_q);
        pending_d = (pending_q & ~pend_clr) | edge_set;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            prev_q    <= in_filt;
            irq_q     <= |pending_q;
        end
    end

    always_comb begin
        rsel = '0;
        unique case (addr)
            ADDR_OUT:     rsel = out_q;
            ADDR_DIR:     rsel = dir_q;
            ADDR_IN:      rsel = in_filt;
            ADDR_RISE_EN: rsel = rise_en_q;
            ADDR_FALL_EN: rsel = fall_en_q;
            ADDR_PENDING: rsel = pending_q;
            default:      rsel = '0;
        endcase
    end

    assign DATA_OUT = BITS'(rsel);
    assign PINS_OUT = out_q;
    assign PINS_OE  = dir_q;
    assign IRQ      = irq_q;

endmodule
